// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - iterative unsigned shift-add multiplier driving an external adder
// One partial-product step per clock; the full product is handed off through a valid/ready handshake.
module seq_shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [WIDTH-1:0]   In_A,
  input  logic [WIDTH-1:0]   In_B,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic [WIDTH-1:0]   Add_A,
  output logic [WIDTH-1:0]   Add_B,
  output logic               Add_Cin,
  input  logic [WIDTH-1:0]   Add_Sum,
  input  logic               Add_Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m, hi, lo;
  logic [CW-1:0]    cnt;
  logic             last_step;

  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (In_Valid) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (Out_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The adder's carry-out lands in the top bit of hi, so no product bit is ever lost.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            m   <= In_A;
            lo  <= In_B;
            hi  <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          hi  <= {Add_Cout, Add_Sum[WIDTH-1:1]};
          lo  <= {Add_Sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign In_Ready  = (state == IDLE) & Rst_n;
  assign Out_Valid = (state == DONE);
  assign Busy      = (state != IDLE);
  assign Product   = {hi, lo};
  assign Add_A     = (state == BUSY) ? hi : '0;
  assign Add_B     = ((state == BUSY) && lo[0]) ? m : '0;
  assign Add_Cin   = 1'b0;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - scoreboard bench for seq_shift_add_mult with a behavioural adder
module tb_seq_shift_add_mult;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0]   in_a, in_b, add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     add_res;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    int                 e;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_sum  = add_res[WIDTH-1:0];
  assign add_cout = add_res[WIDTH];

  seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
    .In_A(in_a), .In_B(in_b), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Product(product), .Busy(busy), .Add_A(add_a), .Add_B(add_b),
    .Add_Cin(add_cin), .Add_Sum(add_sum), .Add_Cout(add_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented product against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      chk("add_cin", 64'(add_cin), 64'd0);
      if (busy) chk("in_ready_while_busy", 64'(in_ready), 64'd0);
      else begin
        chk("add_a_idle", 64'(add_a), 64'd0);
        chk("add_b_idle", 64'(add_b), 64'd0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - exp_q[0].e), 64'(WIDTH));
          chk("product", product, exp_q[0].p);
          chk("busy_in_done", 64'(busy), 64'd1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int edge_no);
    bit ok = 1'b0;
    edge_no = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      edge_no = cyc + 1;
      exp_q.push_back('{p: {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}, e: edge_no});
    end else begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int e, prev_e;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    do_op(32'd3, 32'd5, e);                 wait_drain();
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, e);   wait_drain();
    do_op(32'h0000FFFF, 32'h0000FFFF, e);   wait_drain();
    do_op(32'd0, 32'hDEADBEEF, e);          wait_drain();
    do_op(32'hDEADBEEF, 32'd0, e);          wait_drain();
    do_op(32'd1, 32'h80000000, e);          wait_drain();

    // Backpressure: result held for 10 cycles while extra operands are offered.
    out_ready = 1'b0;
    do_op(32'hCAFEBABE, 32'h12345678, e);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_out_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0]; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a multiplication discards it.
    do_op(32'h12345678, 32'h9ABCDEF0, e);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_product", product, 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_add_a", 64'(add_a), 64'd0);
    chk("midrst_add_b", 64'(add_b), 64'd0);
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    do_op(32'd7, 32'd6, e);                 wait_drain();

    // Back-to-back random operands with the consumer always ready.
    prev_e = 0;
    for (int i = 0; i < 100; i++) begin
      do_op($urandom, $urandom, e);
      if (i > 0) chk("initiation_interval", 64'(e - prev_e), 64'(WIDTH + 2));
      prev_e = e;
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
